// File: rtl/burst_process_engine.sv
// Buffers a burst of up to DEPTH words, then reduces them with sum/xor/max/min into one result.
// Latency: last input handshake at T -> L reduction cycles -> res_valid from T+L+1.
// Backpressure: in_ready only in LOAD (source may stall freely); result held stable until res_ready.
// Optional: define BURST_PROCESS_PARITY_EN to add in_parity input and sticky par_err output.
module burst_process_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int RW = WIDTH + AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [1:0]    op,
    output logic          busy,
    input  logic          in_valid,
    input  logic [WIDTH-1:0] in_data,
`ifdef BURST_PROCESS_PARITY_EN
    input  logic          in_parity,
    output logic          par_err,
`endif
    output logic          in_ready,
    output logic          res_valid,
    output logic [RW-1:0] res_data,
    input  logic          res_ready,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PROCESS, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t          state, state_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [1:0]      op_q;
    logic [AW:0]     len_q, wr_cnt, rd_cnt, len_eff;
    logic [RW-1:0]   acc, acc_nx, acc_init, rd_ext;
    logic            done_q, wr_en, wr_last, rd_last, start_ok;

    // Effective length, accumulator seed and read-side word for the current cycle
    always_comb begin
        len_eff  = (len == '0 || len > DEPTH_L) ? DEPTH_L : len;
        acc_init = (op == 2'd3) ? {{AW{1'b0}}, {WIDTH{1'b1}}} : '0;
        start_ok = (state == S_IDLE) && start;
        wr_en    = (state == S_LOAD) && in_valid;
        wr_last  = (wr_cnt == len_q - ONE);
        rd_last  = (rd_cnt == len_q - ONE);
        rd_ext   = {{AW{1'b0}}, mem[rd_cnt[AW-1:0]]};
    end

    // One reduction step: combine the accumulator with the word being read
    always_comb begin
        acc_nx = acc;
        case (op_q)
            2'd0: acc_nx = acc + rd_ext;
            2'd1: acc_nx = acc ^ rd_ext;
            2'd2: acc_nx = (rd_ext > acc) ? rd_ext : acc;
            default: acc_nx = (rd_ext < acc) ? rd_ext : acc;
        endcase
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && wr_last) state_nx = S_PROCESS;
            end
            S_PROCESS: begin
                if (rd_last) state_nx = S_DONE;
            end
            default: begin
                res_valid = 1'b1;
                res_data  = acc;
                if (res_ready) state_nx = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Burst configuration, address counters, accumulator and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= 2'd0;
            len_q  <= '0;
            wr_cnt <= '0;
            rd_cnt <= '0;
            acc    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == S_DONE) && res_ready;
            if (start_ok) begin
                op_q   <= op;
                len_q  <= len_eff;
                wr_cnt <= '0;
                rd_cnt <= '0;
                acc    <= acc_init;
            end
            if (wr_en) wr_cnt <= wr_cnt + ONE;
            if (state == S_PROCESS) begin
                acc    <= acc_nx;
                rd_cnt <= rd_cnt + ONE;
            end
        end
    end

    // Burst storage; contents are don't-care until written in LOAD
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt[AW-1:0]] <= in_data;
    end

    assign done = done_q;

`ifdef BURST_PROCESS_PARITY_EN
    logic par_err_q;
    // Sticky even-parity error over accepted words, cleared when a new burst starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  par_err_q <= 1'b0;
        else if (start_ok)                        par_err_q <= 1'b0;
        else if (wr_en && ^{in_data, in_parity})  par_err_q <= 1'b1;
    end
    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_burst_process_engine.sv
// Directed bench for burst_process_engine (WIDTH=8, DEPTH=16, RW=12).
// Drives and samples 1 time unit after each rising edge.
// Expected values are hand-computed per scenario.
module tb_burst_process_engine;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, res_ready;
    logic [4:0]  len;
    logic [1:0]  op;
    logic [7:0]  in_data;
    logic        busy, in_ready, res_valid, done;
    logic [11:0] res_data;
`ifdef BURST_PROCESS_PARITY_EN
    logic        in_parity, par_err;
`endif

    int checks = 0;
    int errors = 0;

    burst_process_engine #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .op(op), .busy(busy),
        .in_valid(in_valid), .in_data(in_data),
`ifdef BURST_PROCESS_PARITY_EN
        .in_parity(in_parity), .par_err(par_err),
`endif
        .in_ready(in_ready), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] l, input logic [1:0] o);
        start = 1'b1; len = l; op = o;
        tick();
        start = 1'b0; len = 5'd9; op = 2'd1;
    endtask

    task automatic feed(input logic [7:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Called at T+1 after the last input handshake; cyc ends at L+1 when res_valid rises
    task automatic wait_result(output int cyc);
        cyc = 1;
        while (!res_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; len = 0; op = 0; in_valid = 0; in_data = 0; res_ready = 0;
`ifdef BURST_PROCESS_PARITY_EN
        in_parity = 0;
`endif
        tick(); tick();
        checks++;
        if ({busy, in_ready, res_valid, done, res_data} !== 16'h0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {busy, in_ready, res_valid, done, res_data});
        end
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        checks++;
        if ({busy, in_ready} !== 2'b00) begin
            errors++; $display("FAIL idle_ignores_input: busy/in_ready got %b want 00", {busy, in_ready});
        end
        in_valid = 1'b0;
    endtask

    task automatic test_sum_back_to_back;
        int cyc;
        do_start(5'd4, 2'd0);
        checks++;
        if ({busy, in_ready} !== 2'b11) begin
            errors++; $display("FAIL load_entry: busy/in_ready got %b want 11", {busy, in_ready});
        end
        for (int i = 1; i <= 4; i++) feed(8'(i));
        checks++;
        if ({in_ready, res_valid} !== 2'b00) begin
            errors++; $display("FAIL process_entry: in_ready/res_valid got %b want 00", {in_ready, res_valid});
        end
        wait_result(cyc);
        checks++;
        if (cyc !== 5) begin
            errors++; $display("FAIL sum4_latency: got %0d want 5", cyc);
        end
        checks++;
        if (res_data !== 12'd10 || done !== 1'b0) begin
            errors++; $display("FAIL sum4_result: res_data %0d done %b want 10 0", res_data, done);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if ({done, busy, res_valid} !== 3'b100) begin
            errors++; $display("FAIL done_pulse: done/busy/res_valid got %b want 100", {done, busy, res_valid});
        end
        // start in the done cycle is honoured
        do_start(5'd1, 2'd0);
        checks++;
        if ({done, busy, in_ready} !== 3'b011) begin
            errors++; $display("FAIL start_on_done: done/busy/in_ready got %b want 011", {done, busy, in_ready});
        end
        feed(8'd9);
        wait_result(cyc);
        checks++;
        if (cyc !== 2 || res_data !== 12'd9) begin
            errors++; $display("FAIL len1_result: cyc %0d data %0d want 2 9", cyc, res_data);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_full_depth;
        int cyc;
        int w[16] = '{7, 3, 12, 0, 15, 9, 1, 14, 5, 10, 2, 13, 8, 4, 11, 6};
        do_start(5'd0, 2'd0);
        for (int i = 0; i < 16; i++) feed(8'hFF);
        wait_result(cyc);
        checks++;
        if (cyc !== 17 || res_data !== 12'hFF0) begin
            errors++; $display("FAIL sum16_ff: cyc %0d data %h want 17 ff0", cyc, res_data);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        do_start(5'd16, 2'd2);
        for (int i = 0; i < 16; i++) feed(8'(w[i]));
        wait_result(cyc);
        checks++;
        if (cyc !== 17 || res_data !== 12'd15) begin
            errors++; $display("FAIL max16: cyc %0d data %0d want 17 15", cyc, res_data);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        // len above DEPTH clamps to 16
        do_start(5'd20, 2'd3);
        for (int i = 0; i < 16; i++) feed(8'(w[15 - i] + 1));
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL clamp_len: in_ready got %b want 0 after 16 words", in_ready);
        end
        wait_result(cyc);
        checks++;
        if (cyc !== 17 || res_data !== 12'd1) begin
            errors++; $display("FAIL min16_clamp: cyc %0d data %0d want 17 1", cyc, res_data);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        do_start(5'd16, 2'd3);
        for (int i = 0; i < 16; i++) feed(8'(w[i]));
        wait_result(cyc);
        checks++;
        if (res_data !== 12'd0) begin
            errors++; $display("FAIL min16: data %0d want 0", res_data);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_xor_gaps;
        int cyc;
        logic [7:0] w[3] = '{8'hA5, 8'h0F, 8'hFF};
        int stall_bad = 0;
        do_start(5'd3, 2'd1);
        for (int i = 0; i < 3; i++) begin
            feed(w[i]);
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    if (in_ready !== 1'b1) stall_bad++;
                    tick();
                end
            end
        end
        checks++;
        if (stall_bad !== 0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL xor_stall: bad_ready %0d in_ready %b want 0 0", stall_bad, in_ready);
        end
        wait_result(cyc);
        checks++;
        if (cyc !== 4 || res_data !== 12'h055) begin
            errors++; $display("FAIL xor3: cyc %0d data %h want 4 055", cyc, res_data);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int held_bad = 0;
        do_start(5'd2, 2'd0);
        start = 1'b1; tick(); start = 1'b0;      // ignored in LOAD
        feed(8'd3);
        feed(8'd5);
        start = 1'b1; tick(); tick(); start = 1'b0;   // ignored in PROCESS
        checks++;
        if (res_valid !== 1'b1 || res_data !== 12'd8) begin
            errors++; $display("FAIL bp_result: valid %b data %0d want 1 8", res_valid, res_data);
        end
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== 12'd8 || done !== 1'b0) held_bad++;
        end
        start = 1'b0;
        checks++;
        if (held_bad !== 0) begin
            errors++; $display("FAIL bp_hold: bad cycles %0d want 0", held_bad);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++; $display("FAIL bp_done: done/busy got %b want 10", {done, busy});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle: got %b want 0", done);
        end
    endtask

    task automatic test_mid_reset;
        int cyc;
        do_start(5'd5, 2'd0);
        feed(8'd20);
        feed(8'd30);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, in_ready, res_valid, done, res_data} !== 16'h0) begin
            errors++; $display("FAIL mid_reset: got %h want 0", {busy, in_ready, res_valid, done, res_data});
        end
        tick();
        rst = 1'b0;
        do_start(5'd1, 2'd0);
        feed(8'd7);
        wait_result(cyc);
        checks++;
        if (cyc !== 2 || res_data !== 12'd7) begin
            errors++; $display("FAIL after_reset: cyc %0d data %0d want 2 7", cyc, res_data);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL after_reset_done: got %b want 1", done);
        end
    endtask

`ifdef BURST_PROCESS_PARITY_EN
    task automatic test_parity;
        int cyc;
        do_start(5'd1, 2'd0);
        in_parity = 1'b0;
        feed(8'h01);
        checks++;
        if (par_err !== 1'b1) begin
            errors++; $display("FAIL par_set: got %b want 1", par_err);
        end
        wait_result(cyc);
        checks++;
        if (par_err !== 1'b1 || res_data !== 12'd1) begin
            errors++; $display("FAIL par_done: par_err %b data %0d want 1 1", par_err, res_data);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        do_start(5'd1, 2'd0);
        checks++;
        if (par_err !== 1'b0) begin
            errors++; $display("FAIL par_clear: got %b want 0", par_err);
        end
        feed(8'h03);
        wait_result(cyc);
        checks++;
        if (par_err !== 1'b0) begin
            errors++; $display("FAIL par_good_word: got %b want 0", par_err);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sum_back_to_back();
        test_full_depth();
        test_xor_gaps();
        test_backpressure();
        test_mid_reset();
`ifdef BURST_PROCESS_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
